// File: rtl/leve1_pkg.sv
// Shared types and constants for the LEVE1 instruction-fetch front end.
package leve1_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

  // One buffered fetch result: the word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a redirect target are ignored.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/leve1_if_fetch_if.sv
// Bus bundle of the fetch front end: EX redirect inputs, instruction-memory port and the
// downstream valid/ready instruction stream. The master modport is the fetch unit's view.
interface leve1_if_fetch_if;
  import leve1_pkg::*;

  // EX redirect
  logic            ipc_we;
  logic [XLEN-1:0] inext_pc;
  logic            iflash;

  // Instruction memory port
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;

  // Downstream instruction stream
  logic            ovalid;
  logic [XLEN-1:0] opc;
  logic [31:0]     oinstr;
  logic            iready;

  modport master (
    input  ipc_we, inext_pc, iflash,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output ovalid, opc, oinstr,
    input  iready
  );

  modport slave (
    output ipc_we, inext_pc, iflash,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  ovalid, opc, oinstr,
    output iready
  );

endinterface

// File: rtl/leve1_fifo.sv
// Synchronous FIFO with registered storage, synchronous clear and occupancy count.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module leve1_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  T                wdata_i,
  input  logic            pop_i,
  output T                rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthC);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next state; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents behind the read pointer are don't-care, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/leve1_if_fetch.sv
// LEVE1 instruction-fetch front end. Owns the fetch PC, issues in-order word requests,
// tags returned words with their PC and buffers them for the downstream valid/ready stream.
// An EX redirect reloads both PCs, clears the buffer and drops every response still in
// flight, so stale words never alias the new stream.
// Build option: define LEVE1_IF_BYPASS_EN to present a response in its arrival cycle when
// the buffer is empty (otherwise responses reach the output one cycle after arrival).
module leve1_if_fetch
  import leve1_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input logic              CLK,
  input logic              RSTn,
  leve1_if_fetch_if.master bus
);

  localparam int unsigned  CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  // fpc: address of the next request; rpc: PC tagged onto the next accepted response.
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  // Requests granted but not yet answered, and how many of those are stale.
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            credit_ok;
  logic            req;
  logic            grant;
  logic            resp;
  logic            accept;
  logic            byp_valid;
  logic            byp_take;
  logic            push;
  logic            pop;

  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;

  logic            ovalid;
  logic [XLEN-1:0] opc;
  logic [31:0]     oinstr;

  // IFLASH always accompanies IPC_WE; either one starts a redirect.
  assign redirect = bus.ipc_we | bus.iflash;
  assign target   = align_pc(bus.inext_pc);

  // Every granted request owns a buffer slot, so the buffer can never overflow.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, fifo_count}) < DepthW;
  assign req       = RSTn && credit_ok && !redirect;
  assign grant     = req && bus.mem_gnt;
  assign resp      = bus.mem_rvalid;

  // A response enters the stream only once all stale responses are gone; one arriving in
  // the redirect cycle itself is stale too.
  assign accept = RSTn && resp && (discard_q == '0) && !redirect;

`ifdef LEVE1_IF_BYPASS_EN
  assign byp_valid = accept && fifo_empty;
  assign byp_take  = byp_valid && bus.iready;
`else
  assign byp_valid = 1'b0;
  assign byp_take  = 1'b0;
`endif

  assign push       = accept && !byp_take;
  assign pop        = !fifo_empty && bus.iready && !redirect;
  assign push_entry = '{pc: rpc_q, instr: bus.mem_rdata};

  leve1_fifo #(
    .T     (fetch_entry_t),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .clear_i (redirect),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Outstanding/discard accounting and PC advance; a redirect overrides both PCs.
  always_comb begin
    unique case ({grant, resp})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    discard_d = discard_q;
    if (redirect) begin
      discard_d = outst_d;
    end else if (resp && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    fpc_d = fpc_q;
    rpc_d = rpc_q;
    if (redirect) begin
      fpc_d = target;
      rpc_d = target;
    end else begin
      if (grant)  fpc_d = fpc_q + PC_STEP;
      if (accept) rpc_d = rpc_q + PC_STEP;
    end
  end

  // Fetch state registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fpc_q     <= RESET_PC;
      rpc_q     <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      fpc_q     <= fpc_d;
      rpc_q     <= rpc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  // Downstream view: buffer head, else the bypassed response, else an idle NOP at rpc.
  always_comb begin
    ovalid = 1'b0;
    opc    = rpc_q;
    oinstr = NOP_INSTR;
    if (!fifo_empty) begin
      ovalid = 1'b1;
      opc    = head.pc;
      oinstr = head.instr;
    end else if (byp_valid) begin
      ovalid = 1'b1;
      opc    = rpc_q;
      oinstr = bus.mem_rdata;
    end
  end

  assign bus.mem_req  = req;
  assign bus.mem_addr = fpc_q;
  assign bus.ovalid   = ovalid;
  assign bus.opc      = opc;
  assign bus.oinstr   = oinstr;

  a_resp_has_owner: assert property (@(posedge CLK) disable iff (!RSTn)
    resp |-> (outst_q != '0));
  a_outst_bound: assert property (@(posedge CLK) disable iff (!RSTn)
    {1'b0, outst_q} <= DepthW);
  a_discard_bound: assert property (@(posedge CLK) disable iff (!RSTn)
    discard_q <= outst_q);
  a_no_push_when_full: assert property (@(posedge CLK) disable iff (!RSTn)
    !(push && fifo_full && !pop));
  a_addr_aligned: assert property (@(posedge CLK) disable iff (!RSTn)
    bus.mem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_leve1_if_fetch.sv
// Directed bench for the fetch front end: a one-cycle-latency in-order memory model,
// recording of every grant and every completed downstream handshake, and hand-computed
// expected addresses, PCs and instruction words.
module tb_leve1_if_fetch;
  import leve1_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  leve1_if_fetch_if bus ();

  leve1_if_fetch #(
    .RESET_PC   (64'h0000_0000_8000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic        rsp_en;
  logic [63:0] mq[$];       // granted, not yet answered
  logic [63:0] gnt_q[$];    // every granted address
  logic [63:0] pop_pc[$];   // PC of every completed handshake
  logic [31:0] pop_ins[$];  // instruction of every completed handshake

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: word at address a is a[31:0] ^ 32'hDEAD_0000.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [63:0] gnt_at(input int i);
    return (i < gnt_q.size()) ? gnt_q[i] : '1;
  endfunction

  function automatic logic [63:0] pc_at(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : '1;
  endfunction

  function automatic logic [31:0] ins_at(input int i);
    return (i < pop_ins.size()) ? pop_ins[i] : '1;
  endfunction

  task automatic mem_drive();
    if (rsp_en && mq.size() > 0) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(mq[0]);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h0;
    end
  endtask

  task automatic clear_logs();
    gnt_q.delete();
    pop_pc.delete();
    pop_ins.delete();
  endtask

  // One clock: sample what the edge will see, let it happen, update the memory model.
  // Called and returns at negedge + 1.
  task automatic cyc();
    logic        g, r;
    logic [63:0] a;
    #1;
    g = bus.mem_req && bus.mem_gnt;
    r = bus.mem_rvalid;
    a = bus.mem_addr;
    if (bus.ovalid && bus.iready && !bus.ipc_we) begin
      pop_pc.push_back(bus.opc);
      pop_ins.push_back(bus.oinstr);
    end
    @(posedge clk);
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (g) begin
      mq.push_back(a);
      gnt_q.push_back(a);
    end
    @(negedge clk);
    mem_drive();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.ipc_we   = 1'b0;
    bus.iflash   = 1'b0;
    bus.inext_pc = '0;
    bus.mem_gnt  = 1'b0;
    bus.iready   = 1'b0;
    rsp_en       = 1'b0;
    mq.delete();
    clear_logs();
    mem_drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic redirect_on(input logic [63:0] tgt);
    bus.ipc_we   = 1'b1;
    bus.iflash   = 1'b1;
    bus.inext_pc = tgt;
  endtask

  task automatic redirect_off();
    bus.ipc_we = 1'b0;
    bus.iflash = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ipc_we   = 1'b0;
    bus.iflash   = 1'b0;
    bus.inext_pc = '0;
    bus.mem_gnt  = 1'b0;
    bus.iready   = 1'b0;
    rsp_en       = 1'b0;
    mem_drive();
    repeat (2) @(negedge clk);
    #1;

    // Reset state
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_ovalid",  64'(bus.ovalid),  64'd0);
    check("rst_opc",     bus.opc,          64'h0000_0000_8000_0000);
    check("rst_oinstr",  64'(bus.oinstr),  64'h0000_0013);

    // Streaming from reset, 1-cycle memory, consumer always ready
    do_reset();
    check("t1_first_req",  64'(bus.mem_req), 64'd1);
    check("t1_first_addr", bus.mem_addr,     64'h0000_0000_8000_0000);
    bus.mem_gnt = 1'b1;
    bus.iready  = 1'b1;
    rsp_en      = 1'b1;
    cyc();
    check("t1_ovalid_before_push", 64'(bus.ovalid), 64'd0);
    cyc();
    check("t1_ovalid_after_push", 64'(bus.ovalid), 64'd1);
    check("t1_head_pc",           bus.opc,         64'h0000_0000_8000_0000);
    run(8);
    check("t1_gnt0", gnt_at(0), 64'h0000_0000_8000_0000);
    check("t1_gnt1", gnt_at(1), 64'h0000_0000_8000_0004);
    check("t1_gnt2", gnt_at(2), 64'h0000_0000_8000_0008);
    check("t1_pc0",  pc_at(0),  64'h0000_0000_8000_0000);
    check("t1_ins0", 64'(ins_at(0)), 64'h5EAD_0000);
    check("t1_pc1",  pc_at(1),  64'h0000_0000_8000_0004);
    check("t1_ins1", 64'(ins_at(1)), 64'h5EAD_0004);
    check("t1_pc3",  pc_at(3),  64'h0000_0000_8000_000C);
    check("t1_ins3", 64'(ins_at(3)), 64'h5EAD_000C);

    // Backpressure: credits stop requests at FIFO_DEPTH, one pop frees exactly one
    do_reset();
    bus.mem_gnt = 1'b1;
    rsp_en      = 1'b1;
    run(10);
    check("t2_grants_full", 64'(gnt_q.size()), 64'd4);
    check("t2_req_stalled", 64'(bus.mem_req),  64'd0);
    check("t2_head_pc",     bus.opc,           64'h0000_0000_8000_0000);
    bus.iready = 1'b1;
    cyc();
    bus.iready = 1'b0;
    #1;
    check("t2_req_after_pop",  64'(bus.mem_req), 64'd1);
    check("t2_addr_after_pop", bus.mem_addr,     64'h0000_0000_8000_0010);
    run(4);
    check("t2_grants_total", 64'(gnt_q.size()), 64'd5);
    check("t2_req_stalled2", 64'(bus.mem_req),  64'd0);
    check("t2_new_head_pc",  bus.opc,           64'h0000_0000_8000_0004);

    // Redirect with two requests outstanding: both stale responses are dropped
    do_reset();
    bus.mem_gnt = 1'b1;
    bus.iready  = 1'b1;
    run(2);
    bus.mem_gnt = 1'b0;
    redirect_on(64'h0000_0000_8000_0100);
    bus.mem_gnt = 1'b1;
    rsp_en      = 1'b1;
    #1;
    check("t3_no_req_in_redirect", 64'(bus.mem_req), 64'd0);
    cyc();
    redirect_off();
    check("t3_ovalid_after_redirect", 64'(bus.ovalid), 64'd0);
    run(8);
    check("t3_gnt_after", gnt_at(2), 64'h0000_0000_8000_0100);
    check("t3_pc0",  pc_at(0), 64'h0000_0000_8000_0100);
    check("t3_ins0", 64'(ins_at(0)), 64'h5EAD_0100);
    check("t3_pc1",  pc_at(1), 64'h0000_0000_8000_0104);
    check("t3_ins1", 64'(ins_at(1)), 64'h5EAD_0104);

    // Redirect coinciding with a response and a pop; misaligned target
    do_reset();
    bus.mem_gnt = 1'b1;
    bus.iready  = 1'b1;
    rsp_en      = 1'b1;
    run(5);
    check("t4_pre_ovalid", 64'(bus.ovalid), 64'd1);
    redirect_on(64'h0000_0000_8000_0102);
    cyc();
    redirect_off();
    check("t4_ovalid_after", 64'(bus.ovalid), 64'd0);
    clear_logs();
    run(8);
    check("t4_gnt0", gnt_at(0), 64'h0000_0000_8000_0100);
    check("t4_pc0",  pc_at(0),  64'h0000_0000_8000_0100);
    check("t4_ins0", 64'(ins_at(0)), 64'h5EAD_0100);

    // Back-to-back redirects: 0x200 then 0x300, the second with a stale response arriving
    do_reset();
    bus.mem_gnt = 1'b1;
    bus.iready  = 1'b1;
    run(2);
    redirect_on(64'h0000_0000_0000_0200);
    rsp_en = 1'b1;
    cyc();
    redirect_on(64'h0000_0000_0000_0300);
    cyc();
    redirect_off();
    clear_logs();
    run(8);
    check("t5_gnt0", gnt_at(0), 64'h0000_0000_0000_0300);
    check("t5_pc0",  pc_at(0),  64'h0000_0000_0000_0300);
    check("t5_ins0", 64'(ins_at(0)), 64'hDEAD_0300);
    check("t5_pc1",  pc_at(1),  64'h0000_0000_0000_0304);

    // Reset mid-stream with three buffered entries
    do_reset();
    bus.mem_gnt = 1'b1;
    rsp_en      = 1'b1;
    run(3);
    bus.mem_gnt = 1'b0;
    run(3);
    check("t6_pre_ovalid", 64'(bus.ovalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req",    64'(bus.mem_req), 64'd0);
    check("t6_rst_ovalid", 64'(bus.ovalid),  64'd0);
    check("t6_rst_opc",    bus.opc,          64'h0000_0000_8000_0000);
    do_reset();
    check("t6_restart_req",  64'(bus.mem_req), 64'd1);
    check("t6_restart_addr", bus.mem_addr,     64'h0000_0000_8000_0000);
    bus.mem_gnt = 1'b1;
    bus.iready  = 1'b1;
    rsp_en      = 1'b1;
    run(6);
    check("t6_pc0", pc_at(0), 64'h0000_0000_8000_0000);

    // PC wraps modulo 2^64
    do_reset();
    bus.mem_gnt = 1'b1;
    bus.iready  = 1'b1;
    rsp_en      = 1'b1;
    redirect_on(64'hFFFF_FFFF_FFFF_FFFE);
    cyc();
    redirect_off();
    clear_logs();
    run(6);
    check("t7_gnt0", gnt_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_gnt1", gnt_at(1), 64'h0000_0000_0000_0000);
    check("t7_pc0",  pc_at(0),  64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_ins0", 64'(ins_at(0)), 64'h2152_FFFC);
    check("t7_pc1",  pc_at(1),  64'h0000_0000_0000_0000);
    check("t7_ins1", 64'(ins_at(1)), 64'hDEAD_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
